// File: rtl/uart_rx_frame.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling with false-start rejection,
// optional parity, 1-2 stop bits, valid/ready hold register with overrun pulse.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned MAJ = 1;
`else
  localparam int unsigned MAJ = 0;
`endif

  // With majority voting the decision moves one cycle later; later bits inherit the offset.
  localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2 - 1 + MAJ);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    RECOVER
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   samp;
  logic [CW-1:0]          clk_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_err;
  logic                   fe_acc;
  logic                   frame_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_d1;
  logic rx_d2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  always_comb begin
    samp = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
  end
`else
  always_comb begin
    samp = rx_s;
  end
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      par_err       <= 1'b0;
      fe_acc        <= 1'b0;
      frame_done    <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            clk_cnt <= '0;
            bit_cnt <= '0;
            par_err <= 1'b0;
            fe_acc  <= 1'b0;
          end
        end

        START: begin
          if (clk_cnt == START_LAST) begin
            clk_cnt <= '0;
            state   <= samp ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {samp, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            par_err <= (^shift_reg) ^ samp ^ (PARITY_MODE == 2);
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            fe_acc  <= fe_acc | ~samp;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt    <= '0;
              frame_done <= 1'b1;
              state      <= samp ? IDLE : RECOVER;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        RECOVER: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Completion is resolved one cycle after the last stop sample, against the hold register.
      if (frame_done) begin
        if (!data_valid || data_ready) begin
          data_out      <= shift_reg;
          parity_error  <= par_err;
          framing_error <= fe_acc;
          data_valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at CLKS_PER_BIT=8, 8 data bits, even parity, 1 stop bit.
module tb_uart_rx_frame;

  localparam int unsigned CPB = 8;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_error;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int n_tests;
  int n_fail;
  int ov_cnt;
  int ov_base;

  uart_rx_frame #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .PARITY_MODE (1),
    .STOP_BITS   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .overrun      (overrun),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ov_cnt = 0;
  always @(negedge clk) begin
    if (overrun === 1'b1) ov_cnt = ov_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    @(negedge clk);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(par);
    bit_time(stop);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (data_valid !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(data_valid), 32'h1);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rx         = 1'b1;
    data_ready = 1'b0;
    reset      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_pe",    32'(parity_error), 32'h0);
    check("rst_fe",    32'(framing_error), 32'h0);
    check("rst_ov",    32'(overrun), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5 has four ones: even parity bit 0
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_valid("a5_valid");
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_pe",   32'(parity_error), 32'h0);
    check("a5_fe",   32'(framing_error), 32'h0);
    pulse_ready();
    check("a5_clear", 32'(data_valid), 32'h0);
    check("a5_hold",  32'(data_out), 32'hA5);

    // Wrong parity bit
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_valid("a5p_valid");
    check("a5p_data", 32'(data_out), 32'hA5);
    check("a5p_pe",   32'(parity_error), 32'h1);
    pulse_ready();
    check("a5p_pe_kept", 32'(parity_error), 32'h1);
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_valid("3c_valid");
    check("3c_data", 32'(data_out), 32'h3C);
    check("3c_pe",   32'(parity_error), 32'h0);
    pulse_ready();

    // False start: 3 clk low glitch
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("fs_busy_hi", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check("fs_busy_lo", 32'(busy), 32'h0);
    check("fs_valid",   32'(data_valid), 32'h0);
    send_frame(8'h11, 1'b0, 1'b1);
    wait_valid("11_valid");
    check("11_data", 32'(data_out), 32'h11);
    check("11_pe",   32'(parity_error), 32'h0);
    pulse_ready();

    // Framing error followed by a held-low break
    send_frame(8'h7E, 1'b0, 1'b0);
    wait_valid("7e_valid");
    check("7e_data", 32'(data_out), 32'h7E);
    check("7e_fe",   32'(framing_error), 32'h1);
    check("7e_pe",   32'(parity_error), 32'h0);
    pulse_ready();
    repeat (28) @(negedge clk);
    check("brk_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_idle", 32'(busy), 32'h0);
    repeat (100) @(negedge clk);
    check("brk_no_frame", 32'(data_valid), 32'h0);
    check("no_ov_yet", 32'(ov_cnt), 32'h0);

    // Overrun: consumer never ready
    ov_base = ov_cnt;
    send_frame(8'h01, 1'b1, 1'b1);
    wait_valid("01_valid");
    send_frame(8'h02, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("ov_pulses", 32'(ov_cnt - ov_base), 32'h1);
    check("ov_data",   32'(data_out), 32'h01);
    check("ov_valid",  32'(data_valid), 32'h1);

    // Asynchronous reset in the middle of a 0xFF frame
    @(negedge clk);
    bit_time(1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_busy", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("ar_data",  32'(data_out), 32'h0);
    check("ar_valid", 32'(data_valid), 32'h0);
    check("ar_busy",  32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h55, 1'b0, 1'b1);
    wait_valid("55_valid");
    check("55_data", 32'(data_out), 32'h55);
    check("55_pe",   32'(parity_error), 32'h0);
    check("55_fe",   32'(framing_error), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
